ex_stage: RTL

- Execute stage, directly downstream of the ID/EX pipeline register.
- Consumes operands, register indices and control fields, applies EX/MEM and MEM/WB forwarding, and computes the ALU result.
- Runs MUL on an iterative shift-add multiplier that stalls upstream.
- Its output registers form the EX/MEM pipeline register.

---
 rtl/ex_pkg.sv | 30 +++
 rtl/ex_stage_mul_iter.sv | 72 +++++++
 rtl/ex_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, control-field bit
// positions and the multiplier FSM state encoding.
package ex_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    // muxctrl bit positions; bits 6:4 are carried through untouched
    localparam int MC_REGWRITE = 0;
    localparam int MC_REGDST   = 1;
    localparam int MC_ALUSRC   = 2;
    localparam int MC_MEMTOREG = 3;

    // memctrl bit positions (pass-through only)
    localparam int MEMC_READ  = 0;
    localparam int MEMC_WRITE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH
// iterations, low WIDTH bits of the product. Built only under EX_MUL_EN.
module mul_iter
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] product_out
);

    localparam int CW = $clog2(WIDTH);

    mul_state_t       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    // Sequencer and datapath: latch operands on start, then add/shift one bit per BUSY cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_acc   <= '0;
                        r_count <= CW'(WIDTH - 1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_b[0]) begin
                        r_acc <= r_acc + r_a;
                    end
                    r_a <= r_a << 1;
                    r_b <= r_b >> 1;
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall starts combinationally on the request cycle so ID/EX holds the MUL
    assign busy_out    = ((r_state == ST_IDLE) && start) || (r_state == ST_BUSY);
    assign done_out    = (r_state == ST_DONE);
    assign product_out = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding (EX/MEM over MEM/WB), ALU, and the
// EX/MEM pipeline register. MUL uses the iterative multiplier only when the
// EX_MUL_EN macro is defined; otherwise MUL returns 0 in one cycle and the
// stage never stalls.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d1_in,
    input  logic [WIDTH-1:0] d2_in,
    input  logic [15:0]      imm_in,
    input  logic [4:0]       rs_in,
    input  logic [4:0]       rt_in,
    input  logic [4:0]       rd_in,
    input  logic [6:0]       muxctrl_in,
    input  logic [1:0]       memctrl_in,
    input  logic [2:0]       aluctrl_in,
    input  logic [4:0]       wb_rd_in,
    input  logic             wb_regwrite_in,
    input  logic [WIDTH-1:0] wb_data_in,
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic [4:0]       dest_out,
    output logic [6:0]       muxctrl_out,
    output logic [1:0]       memctrl_out,
    output logic             stall_out
);

    logic [WIDTH-1:0]        w_fwd_a;
    logic [WIDTH-1:0]        w_fwd_b;
    logic [WIDTH-1:0]        w_imm_ext;
    logic [WIDTH-1:0]        w_op_b;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [WIDTH-1:0]        w_alu;
    logic [WIDTH-1:0]        w_mul_result;
    logic                    w_stall;

    // Forwarding: the EX/MEM register (this stage's own outputs) wins over MEM/WB; r0 never forwards
    always_comb begin
        if (muxctrl_out[MC_REGWRITE] && (dest_out != 5'd0) && (dest_out == rs_in)) begin
            w_fwd_a = alu_result_out;
        end else if (wb_regwrite_in && (wb_rd_in != 5'd0) && (wb_rd_in == rs_in)) begin
            w_fwd_a = wb_data_in;
        end else begin
            w_fwd_a = d1_in;
        end

        if (muxctrl_out[MC_REGWRITE] && (dest_out != 5'd0) && (dest_out == rt_in)) begin
            w_fwd_b = alu_result_out;
        end else if (wb_regwrite_in && (wb_rd_in != 5'd0) && (wb_rd_in == rt_in)) begin
            w_fwd_b = wb_data_in;
        end else begin
            w_fwd_b = d2_in;
        end
    end

    assign w_imm_ext = {{(WIDTH-16){imm_in[15]}}, imm_in};
    assign w_op_b    = muxctrl_in[MC_ALUSRC] ? w_imm_ext : w_fwd_b;
    assign w_a_s     = w_fwd_a;
    assign w_b_s     = w_op_b;

`ifdef EX_MUL_EN
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock       (clock),
        .reset       (reset),
        .start       (aluctrl_in == ALU_MUL),
        .a_in        (w_fwd_a),
        .b_in        (w_op_b),
        .busy_out    (w_stall),
        .done_out    (w_mul_done),
        .product_out (w_mul_product)
    );

    assign w_mul_result = w_mul_done ? w_mul_product : '0;
`else
    assign w_stall      = 1'b0;
    assign w_mul_result = '0;
`endif

    // ALU: add/sub wrap, SLT is signed, SLL shifts the forwarded rt value by the shamt field
    always_comb begin
        w_alu = '0;
        case (aluctrl_in)
            ALU_ADD: w_alu = w_fwd_a + w_op_b;
            ALU_SUB: w_alu = w_fwd_a - w_op_b;
            ALU_AND: w_alu = w_fwd_a & w_op_b;
            ALU_OR:  w_alu = w_fwd_a | w_op_b;
            ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
            ALU_NOR: w_alu = ~(w_fwd_a | w_op_b);
            ALU_SLL: w_alu = w_fwd_b << imm_in[10:6];
            ALU_MUL: w_alu = w_mul_result;
            default: w_alu = '0;
        endcase
    end

    // EX/MEM register: bubbles while the multiplier stalls, otherwise captures result and held ID/EX fields
    always_ff @(posedge clock) begin
        if (reset || w_stall) begin
            alu_result_out <= '0;
            store_data_out <= '0;
            dest_out       <= '0;
            muxctrl_out    <= '0;
            memctrl_out    <= '0;
        end else begin
            alu_result_out <= w_alu;
            store_data_out <= w_fwd_b;
            dest_out       <= muxctrl_in[MC_REGDST] ? rd_in : rt_in;
            muxctrl_out    <= muxctrl_in;
            memctrl_out    <= memctrl_in;
        end
    end

    assign stall_out = w_stall;

endmodule
